// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state codes, opcodes,
// ALU operation classes and datapath select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // In FETCH, pc_write/ir_write mark the ready-qualified strobes; the top gates them.
  function automatic ctrl_t ctrl_decode(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_OP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG_B;
        c.alu_op    = ALU_OP_FUNC;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG_B;
        c.alu_op        = ALU_OP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back steps and drives all datapath controls.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter logic WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALU_OP,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_r;
  state_e state_next_s;
  ctrl_t  ctrl_r;
  logic   ready_s;

  assign ready_s = WAIT_EN ? mem_ready : 1'b1;
  assign state   = 4'(state_r);

  // Next-state selection; Opcode is only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (ready_s) state_next_s = S_DECODE;
        else         state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_RTYPE:     state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
          OP_ADDI:      state_next_s = S_ADDI_EXEC;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        case (Opcode)
          OP_LW:   state_next_s = S_MEM_READ;
          OP_SW:   state_next_s = S_MEM_WRITE;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        if (ready_s) state_next_s = S_MEM_WB;
        else         state_next_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (ready_s) state_next_s = S_FETCH;
        else         state_next_s = S_MEM_WRITE;
      end
      S_EXECUTE:   state_next_s = S_R_WB;
      S_ADDI_EXEC: state_next_s = S_ADDI_WB;
      default:     state_next_s = S_FETCH;
    endcase
  end

  // State register with the Moore controls registered alongside it, so ctrl_r
  // always equals the decode of state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
      ctrl_r  <= ctrl_decode(S_FETCH);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= ctrl_decode(state_next_s);
    end
  end

  // Output stage: selects pass through; enables are killed during reset and the
  // FETCH strobes are qualified by memory readiness.
  always_comb begin
    IorD     = ctrl_r.ior_d;
    MemtoReg = ctrl_r.mem_to_reg;
    ALUSrcA  = ctrl_r.alu_src_a;
    RegDst   = ctrl_r.reg_dst;
    ALU_OP   = ctrl_r.alu_op;
    ALUSrcB  = ctrl_r.alu_src_b;
    PCSource = ctrl_r.pc_source;
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end else begin
      PCWrite     = ctrl_r.pc_write & (~ctrl_r.ir_write | ready_s);
      PCWriteCond = ctrl_r.pc_write_cond;
      MemRead     = ctrl_r.mem_read;
      MemWrite    = ctrl_r.mem_write;
      IRWrite     = ctrl_r.ir_write & ready_s;
      RegWrite    = ctrl_r.reg_write;
      illegal_op  = (state_r == S_DECODE) & ~op_supported(Opcode);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-instruction step model predicts
// every cycle's controls; literal checks pin reset behaviour and cycle counts.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] ALU_OP, ALUSrcB, PCSource;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALU_OP(ALU_OP), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
    logic [1:0] aluop, asb, pcs;
    logic ill;
  } ctl_t;
  typedef struct { logic [3:0] st; ctl_t ctl; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] req; } pin_t;
  typedef struct { logic [3:0] st; logic [1:0] rdy; } step_t;

  exp_t exp_q[$];
  pin_t pin_q[$];
  int checks = 0, passes = 0;
  int mw_cnt = 0, rw_cnt = 0, m2r_cnt = 0, irw_cnt = 0, ill_cnt = 0;
  int nz_cnt = 0, fetch_cnt = 0;

  // Controls each step must show, straight from the per-step rules.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic r, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mr = 1'b1; c.asb = 2'b01; c.irw = r; c.pcw = r; end
      4'd1:  c.asb = 2'b11;
      4'd2:  begin c.asa = 1'b1; c.asb = 2'b10; end
      4'd3:  begin c.mr = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
      4'd5:  begin c.mw = 1'b1; c.iord = 1'b1; end
      4'd6:  begin c.asa = 1'b1; c.aluop = 2'b10; end
      4'd7:  begin c.rw = 1'b1; c.rd = 1'b1; end
      4'd8:  begin c.asa = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01; end
      4'd9:  begin c.pcw = 1'b1; c.pcs = 2'b10; end
      4'd10: begin c.asa = 1'b1; c.asb = 2'b10; end
      4'd11: c.rw = 1'b1;
      default: c = '0;
    endcase
    if (st == 4'd1 && !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000}))
      c.ill = 1'b1;
    return c;
  endfunction

  task automatic pin(input string n, input logic [31:0] a, input logic [31:0] r);
    pin_q.push_back('{n, a, r});
  endtask

  // Build the step list for one instruction (rdy: 0/1 driven, 2 = don't care) and play it.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int max_cyc);
    step_t seq[$];
    step_t s;
    seq = {};
    for (int i = 0; i < fw; i++) seq.push_back('{4'd0, 2'd0});
    seq.push_back('{4'd0, 2'd1});
    seq.push_back('{4'd1, 2'd2});
    case (op)
      6'b100011: begin
        seq.push_back('{4'd2, 2'd2});
        for (int i = 0; i < mw; i++) seq.push_back('{4'd3, 2'd0});
        seq.push_back('{4'd3, 2'd1});
        seq.push_back('{4'd4, 2'd2});
      end
      6'b101011: begin
        seq.push_back('{4'd2, 2'd2});
        for (int i = 0; i < mw; i++) seq.push_back('{4'd5, 2'd0});
        seq.push_back('{4'd5, 2'd1});
      end
      6'b000000: begin seq.push_back('{4'd6, 2'd2}); seq.push_back('{4'd7, 2'd2}); end
      6'b000100: seq.push_back('{4'd8, 2'd2});
      6'b000010: seq.push_back('{4'd9, 2'd2});
      6'b001000: begin seq.push_back('{4'd10, 2'd2}); seq.push_back('{4'd11, 2'd2}); end
      default: ;
    endcase
    for (int i = 0; i < seq.size() && (max_cyc < 0 || i < max_cyc); i++) begin
      s = seq[i];
      Opcode = (s.st == 4'd1 || s.st == 4'd2) ? op : ~op;
      mem_ready = (s.rdy == 2'd2) ? 1'($urandom_range(0, 1)) : s.rdy[0];
      exp_q.push_back('{s.st, exp_ctl(s.st, s.rdy[0], Opcode)});
      @(posedge clk);
      #1;
    end
  endtask

  // Single compare process: literal pins first, then this cycle's model prediction.
  always @(negedge clk) begin
    ctl_t act;
    exp_t e;
    pin_t p;
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      checks++;
      if (p.act === p.req) passes++;
      else $display("FAIL %s: got %0h, expected %0h", p.name, p.act, p.req);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
             RegWrite, RegDst, ALU_OP, ALUSrcB, PCSource, illegal_op};
      checks++;
      if (act === e.ctl && state === e.st) passes++;
      else $display("FAIL cycle_ctl t=%0t: state %0d ctl %05h, expected state %0d ctl %05h",
                    $time, state, act, e.st, e.ctl);
      mw_cnt    += int'(MemWrite);
      rw_cnt    += int'(RegWrite);
      m2r_cnt   += int'(MemtoReg);
      irw_cnt   += int'(IRWrite);
      ill_cnt   += int'(illegal_op);
      nz_cnt    += int'(state != 4'd0);
      fetch_cnt += int'(state == 4'd0);
    end
  end

  initial begin
    int b_mw, b_rw, b_m2r, b_irw, b_ill, b_nz, b_f;
    reset = 1'b1; Opcode = 6'd0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pin("reset_state", 32'(state), 32'd0);
    pin("reset_enables", 32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op}), 32'd0);
    pin("reset_selects", 32'({ALUSrcB, PCSource, ALU_OP}), 32'b010000);
    reset = 1'b0;
    #1;
    pin("release_memread", 32'(MemRead), 32'd1);

    b_rw = rw_cnt; b_m2r = m2r_cnt; b_nz = nz_cnt;
    run_instr(6'b100011, 0, 0, -1);
    pin("lw_regwrite_cycles", 32'(rw_cnt - b_rw), 32'd1);
    pin("lw_memtoreg_cycles", 32'(m2r_cnt - b_m2r), 32'd1);
    pin("lw_nonfetch_cycles", 32'(nz_cnt - b_nz), 32'd4);

    b_irw = irw_cnt; b_f = fetch_cnt;
    run_instr(6'b000000, 3, 0, -1);
    pin("r_fetch_cycles", 32'(fetch_cnt - b_f), 32'd4);
    pin("r_irwrite_cycles", 32'(irw_cnt - b_irw), 32'd1);

    b_nz = nz_cnt;
    run_instr(6'b000100, 0, 0, -1);
    pin("beq_nonfetch_cycles", 32'(nz_cnt - b_nz), 32'd2);

    run_instr(6'b000010, 0, 0, -1);

    b_mw = mw_cnt; b_nz = nz_cnt;
    run_instr(6'b101011, 0, 2, -1);
    pin("sw_memwrite_cycles", 32'(mw_cnt - b_mw), 32'd3);
    pin("sw_nonfetch_cycles", 32'(nz_cnt - b_nz), 32'd5);

    b_ill = ill_cnt; b_rw = rw_cnt; b_mw = mw_cnt; b_nz = nz_cnt;
    run_instr(6'b111111, 0, 0, -1);
    pin("illegal_pulses", 32'(ill_cnt - b_ill), 32'd1);
    pin("illegal_writes", 32'((rw_cnt - b_rw) + (mw_cnt - b_mw)), 32'd0);
    pin("illegal_nonfetch_cycles", 32'(nz_cnt - b_nz), 32'd1);

    b_rw = rw_cnt;
    run_instr(6'b001000, 1, 0, -1);
    pin("addi_regwrite_cycles", 32'(rw_cnt - b_rw), 32'd1);
    run_instr(6'b100011, 0, 1, -1);

    // Abort a store while it waits on memory.
    run_instr(6'b101011, 0, 5, 4);
    mem_ready = 1'b0;
    pin("pre_abort_memwrite", 32'(MemWrite), 32'd1);
    pin("pre_abort_state", 32'(state), 32'd5);
    reset = 1'b1;
    #1;
    pin("abort_memwrite", 32'(MemWrite), 32'd0);
    pin("abort_state", 32'(state), 32'd0);
    pin("abort_enables", 32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    pin("restart_memread", 32'(MemRead), 32'd1);
    pin("restart_state", 32'(state), 32'd0);
    run_instr(6'b000100, 1, 0, -1);
    run_instr(6'b101011, 0, 0, -1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps, driving every datapath mux select and write enable plus the 2-bit ALU operation class consumed by the ALU control decoder. Sits beside the datapath, observes only the opcode field of the instruction register and a memory-ready handshake, and holds no datapath state of its own.

## Interface
- WAIT_EN, 1: 1 = honour `mem_ready` in memory states; 0 = treat memory as always ready.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- Opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  standard multicycle controls
- ALU_OP  out  2  00 add, 01 subtract, 10 use Func
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse in DECODE for unsupported opcode
- state  out  4  current state code, debug only

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and transitions:
  - FETCH: MemRead, ALUSrcB=01, ALU_OP=00, PCSource=00; IRWrite and PCWrite asserted only when ready; stay until ready, then DECODE.
  - DECODE: ALUSrcB=11, ALU_OP=00 (branch target to ALUOut). Next by Opcode: lw/sw→MEM_ADDR, R→EXECUTE, beq→BRANCH, j→JUMP, addi→ADDI_EXEC, other→FETCH with illegal_op=1.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_OP=00; lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ: MemRead, IorD=1; wait for ready, then MEM_WB.
  - MEM_WB: RegWrite, MemtoReg=1, RegDst=0; →FETCH.
  - MEM_WRITE: MemWrite, IorD=1; wait for ready, then FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_OP=10; →R_WB.
  - R_WB: RegWrite, RegDst=1, MemtoReg=0; →FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_OP=01, PCWriteCond, PCSource=01; →FETCH.
  - JUMP: PCWrite, PCSource=10; →FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_OP=00; →ADDI_WB.
  - ADDI_WB: RegWrite, RegDst=0, MemtoReg=0; →FETCH.
- "ready" = `mem_ready` when WAIT_EN=1, else constant 1.
- Outputs are Moore (state-decoded) except FETCH's IRWrite/PCWrite, which are ANDed with ready. Unlisted outputs are 0 in each state.
- Opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.

## Timing
- Reset: state=FETCH immediately (asynchronous). While reset is high, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and illegal_op are forced 0; selects take FETCH values. State codes: FETCH=0, then 1..11 in the listed order.
- Zero-wait cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of deasserted `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds one cycle. MemRead/MemWrite stay asserted and IorD stays stable throughout the wait.
- Reset asserted mid-instruction aborts it: no further enables, and FETCH restarts on the first edge after release.
- `mem_ready` outside memory states has no effect.

## Structure
- Shared package `mips_ctrl_pkg`: state enum (4-bit), opcode constants, ALU_OP encodings (ADD/SUB/FUNC), ALUSrcB and PCSource encodings. The ALU control decoder uses the same ALU_OP constants.
- Single module: a state register plus a combinational next-state/output block. No sub-module needed.

## Test plan
- Reset mid-MEM_WRITE (MemWrite=1) -> MemWrite drops to 0 immediately; state=0; after release, FETCH with MemRead=1.
- lw (Opcode=100011), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in the 5th cycle only; ALU_OP 00 throughout.
- R-type, mem_ready held low 3 cycles in FETCH -> FETCH lasts 4 cycles; IRWrite/PCWrite high only in the 4th; then EXECUTE with ALU_OP=10 and R_WB with RegDst=1.
- beq -> 3 cycles; BRANCH has ALU_OP=01, PCWriteCond=1, PCSource=01, PCWrite=0.
- j, then sw with 2 wait cycles -> JUMP has PCWrite=1, PCSource=10; sw takes 6 cycles with MemWrite=1 for 3 of them and IorD=1 throughout those 3.
- Opcode=111111 -> illegal_op pulses for 1 cycle in DECODE; next state FETCH; no RegWrite/MemWrite asserted.
